// File: rtl/vip_stream_source.sv
// VIP pipeline head: generates vsync/href/clken frame timing and an 8-bit Y stream
// taken from an upstream valid/ready source or from a built-in test pattern.
module vip_stream_source #(
    parameter logic [10:0] IMG_HDISP = 11'd800,
    parameter logic [10:0] IMG_VDISP = 11'd600,
    parameter logic [10:0] H_BLANK   = 11'd160,
    parameter logic [10:0] V_BLANK   = 11'd20,
    parameter logic [10:0] V_SYNC    = 11'd2,
    parameter logic [7:0]  FILL      = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] pat_sel,
    input  logic       clr_err,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_Y,
    output logic       frame_start,
    output logic       underflow,
    output logic       busy
);

    localparam logic [10:0] HTOTAL = IMG_HDISP + H_BLANK;
    localparam logic [10:0] VTOTAL = V_BLANK + IMG_VDISP;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [1:0]  pat_q;
    logic        vsync_q, href_q, clken_q, fs_q, underflow_q;
    logic [7:0]  pix_q, pix_d;
    logic        run, active, vs_region, origin, h_end, v_end, starve;
    logic [4:0]  y_lo;

    assign run       = (state_q == RUN);
    assign active    = (v_cnt_q >= V_BLANK) && (h_cnt_q < IMG_HDISP);
    assign vs_region = (v_cnt_q < V_SYNC);
    assign origin    = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    assign h_end     = (h_cnt_q == HTOTAL - 11'd1);
    assign v_end     = (v_cnt_q == VTOTAL - 11'd1);
    // Grid only needs y[4:0]; the low bits of v-V_BLANK equal the low-bit difference.
    assign y_lo      = v_cnt_q[4:0] - V_BLANK[4:0];

    assign s_ready = run && (pat_q == 2'd0) && active;
    assign starve  = run && (pat_q == 2'd0) && active && !s_valid;

    always_comb begin
        h_cnt_d = h_end ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_end) begin
            v_cnt_d = v_end ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    always_comb begin
        pix_d = FILL;
        case (pat_q)
            2'd0:    pix_d = s_valid ? s_data : FILL;
            2'd1:    pix_d = h_cnt_q[7:0];
            2'd2:    pix_d = (h_cnt_q[4:0] == 5'd0 || y_lo == 5'd0) ? 8'hFF : 8'h00;
            default: pix_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            pat_q       <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            clken_q     <= 1'b0;
            fs_q        <= 1'b0;
            pix_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (starve) begin
                underflow_q <= 1'b1;
            end else if (clr_err) begin
                underflow_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    vsync_q <= 1'b0;
                    href_q  <= 1'b0;
                    clken_q <= 1'b0;
                    fs_q    <= 1'b0;
                    pix_q   <= '0;
                    if (en) begin
                        state_q <= RUN;
                        pat_q   <= pat_sel;
                    end
                end
                RUN: begin
                    vsync_q <= vs_region;
                    href_q  <= active;
                    clken_q <= active;
                    fs_q    <= origin;
                    pix_q   <= active ? pix_d : 8'd0;
                    h_cnt_q <= h_cnt_d;
                    v_cnt_q <= v_cnt_d;
                    if (origin) begin
                        pat_q <= pat_sel;
                    end
                    // A frame in progress always runs to completion before stopping.
                    if (h_end && v_end && !en) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign post_frame_vsync = vsync_q;
    assign post_frame_href  = href_q;
    assign post_frame_clken = clken_q;
    assign post_img_Y       = pix_q;
    assign frame_start      = fs_q;
    assign underflow        = underflow_q;
    assign busy             = run;

endmodule

// File: tb/tb_vip_stream_source.sv
// Scoreboard bench for vip_stream_source with a small 8x4 frame (12x7 totals, 84 cycles/frame).
module tb_vip_stream_source;

    logic       clk = 1'b0;
    logic       rst_n, en, clr_err, s_valid;
    logic [1:0] pat_sel;
    logic [7:0] s_data;
    logic       s_ready, post_frame_vsync, post_frame_href, post_frame_clken;
    logic [7:0] post_img_Y;
    logic       frame_start, underflow, busy;

    logic [7:0] exp_q[$];
    logic [7:0] mon_e;
    int         n_cmp = 0;
    int         n_fail = 0;

    vip_stream_source #(
        .IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .H_BLANK(11'd4),
        .V_BLANK(11'd3), .V_SYNC(11'd1), .FILL(8'h11)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .clr_err(clr_err),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img_Y(post_img_Y),
        .frame_start(frame_start), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int outs();
        return {20'd0, post_frame_vsync, post_frame_href, post_frame_clken, frame_start, post_img_Y};
    endfunction

    // Monitor: every presented pixel is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (post_frame_clken) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pixel_unexpected: got %0d, expected no pixel", post_img_Y);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pixel", int'(post_img_Y), int'(mon_e));
                end
            end else begin
                chk("y_zero_when_idle", int'(post_img_Y), 0);
            end
        end
    end

    task automatic push_pat(input logic [1:0] p);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                case (p)
                    2'd1:    exp_q.push_back(8'(x));
                    2'd2:    exp_q.push_back((y == 0 || x == 0) ? 8'd255 : 8'd0);
                    default: exp_q.push_back(8'h11);
                endcase
            end
        end
    endtask

    // Called at the negedge where frame_start is expected; returns at the next frame origin.
    task automatic frame_win(input logic [1:0] cur, input logic [1:0] nxt,
                             input bit drop, input bit stop, input bit clr);
        int         fs = 0, vs = 0, hr = 0, ck = 0, rd = 0;
        logic [7:0] d = 8'd0;
        if (cur != 2'd0) push_pat(cur);
        for (int i = 0; i < 84; i++) begin
            if (i == 0) begin
                chk("frame_start_origin", int'(frame_start), 1);
                chk("vsync_at_origin", int'(post_frame_vsync), 1);
            end
            fs += int'(frame_start);
            vs += int'(post_frame_vsync);
            hr += int'(post_frame_href);
            ck += int'(post_frame_clken);
            if (clr && i == 10) begin
                chk("underflow_before_clr", int'(underflow), 1);
                clr_err = 1'b1;
            end
            if (clr && i == 11) clr_err = 1'b0;
            if (clr && i == 12) chk("underflow_after_clr", int'(underflow), 0);
            if (stop && i == 39) en = 1'b0;
            if (i == 40) pat_sel = nxt;
            if (stop && i == 82) chk("busy_last_cycle", int'(busy), 1);
            if (stop && i == 83) chk("busy_after_frame", int'(busy), 0);
            if (s_ready) begin
                rd++;
                if (drop && rd == 3) begin
                    s_valid = 1'b0;
                    s_data  = 8'hEE;
                    exp_q.push_back(8'h11);
                end else begin
                    s_valid = 1'b1;
                    s_data  = d;
                    exp_q.push_back(d);
                    d++;
                end
            end else begin
                s_valid = 1'b1;
                s_data  = 8'hEE;
            end
            @(negedge clk);
        end
        chk("frame_start_count", fs, 1);
        chk("vsync_count", vs, 12);
        chk("href_count", hr, 32);
        chk("clken_count", ck, 32);
        chk("ready_count", rd, (cur == 2'd0) ? 32 : 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; pat_sel = 2'd0; clr_err = 1'b0;
        s_valid = 1'b0; s_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        chk("reset_busy_ready", int'({busy, s_ready}), 0);
        chk("reset_underflow", int'(underflow), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_outputs", outs(), 0);

        en = 1'b1; pat_sel = 2'd1;
        @(negedge clk);
        chk("start_busy", int'(busy), 1);
        chk("start_no_fs", int'(frame_start), 0);
        @(negedge clk);

        frame_win(2'd1, 2'd1, 0, 0, 0);
        frame_win(2'd1, 2'd0, 0, 0, 0);
        frame_win(2'd0, 2'd0, 0, 0, 0);
        chk("underflow_clean_stream", int'(underflow), 0);
        frame_win(2'd0, 2'd1, 1, 0, 0);
        chk("underflow_after_drop", int'(underflow), 1);
        frame_win(2'd1, 2'd2, 0, 0, 1);
        frame_win(2'd2, 2'd3, 0, 0, 0);
        frame_win(2'd3, 2'd1, 0, 1, 0);

        for (int k = 0; k < 8; k++) begin
            chk("idle_hold_outputs", outs(), 0);
            chk("idle_hold_busy_ready", int'({busy, s_ready}), 0);
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        chk("restart_busy", int'(busy), 1);
        chk("restart_no_fs", int'(frame_start), 0);
        @(negedge clk);
        frame_win(2'd1, 2'd1, 0, 0, 0);

        // Reset in the middle of active line y=1.
        push_pat(2'd1);
        repeat (51) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        chk("async_reset_busy_ready", int'({busy, s_ready}), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_quiet", outs(), 0);
        chk("post_reset_busy", int'(busy), 1);
        @(negedge clk);
        frame_win(2'd1, 2'd1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
